// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared RV32 load/store encodings, the mem_access FSM state
// type and small helpers for store lane steering and alignment checks.
package cpu_defs_pkg;

  // Major opcode of every load instruction (stores are flagged by wr_mem_en).
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Bus access sequencer states.
  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_REQ    = 2'd1,
    MEM_WAIT_R = 2'd2
  } mem_state_e;

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] idx);
    logic [3:0] be;
    case (funct3)
      F3_SB:   be = 4'b0001 << idx;
      F3_SH:   be = 4'b0011 << idx;
      F3_SW:   be = 4'b1111;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Store data replicated across every lane so the byte enables pick it out.
  function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                             input logic [31:0] data);
    logic [31:0] wdata;
    case (funct3)
      F3_SB:   wdata = {4{data[7:0]}};
      F3_SH:   wdata = {2{data[15:0]}};
      F3_SW:   wdata = data;
      default: wdata = data;
    endcase
    return wdata;
  endfunction

  // Halfword crossing the word boundary, or word not on a word boundary.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] idx);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = (idx == 2'd3);
      2'b10:   mis = (idx != 2'd0);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/halfword out of a bus read word and
// sign- or zero-extends it according to the load's funct3.
module load_align
  import cpu_defs_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  index,
  output logic [31:0] data
);

  // Addressed lane moved down to bit 0; only the low halfword is ever needed.
  logic [15:0] lane;
  assign lane = 16'(rdata >> {index, 3'b000});

  // Extend the selected lane to the register width.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   data = {{16{lane[15]}}, lane};
      F3_LBU:  data = {24'h000000, lane[7:0]};
      F3_LHU:  data = {16'h0000, lane};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage of the pipeline. Issues one bus access at a time
// for loads and stores, stalls upstream until the access completes, aligns
// load data and registers the write-back bundle.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses
// (no bus request, one-cycle misalign_o pulse, write-back suppressed).
module mem_access
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] reg_wdata_i,
  input  logic        wr_reg_en_i,
  input  logic [4:0]  wr_reg_addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic        wr_mem_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [1:0]  wr_addr_index_i,
  input  logic [1:0]  rd_addr_index_i,
  input  logic [31:0] wr_mem_data_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stall_o,
  output logic [31:0] wb_reg_wdata_o,
  output logic        wb_wr_reg_en_o,
  output logic [4:0]  wb_wr_reg_addr_o,
  output logic [31:0] wb_pc_o,
  output logic [31:0] wb_inst_o,
  output logic        misalign_o
);

  mem_state_e  state_q, state_d;
  logic [2:0]  funct3;
  logic        is_store;
  logic        is_load;
  logic        misaligned;
  logic        mem_op;
  logic        bus_req;
  logic        complete;
  logic [31:0] load_data;

  assign funct3   = inst_i[14:12];
  assign is_store = wr_mem_en_i;
  // A store flag wins over the opcode so a store is never also treated as a load.
  assign is_load  = (inst_i[6:0] == OPC_LOAD) && !is_store;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (is_store && is_misaligned(funct3, wr_addr_index_i)) ||
                      (is_load  && is_misaligned(funct3, rd_addr_index_i));
`else
  assign misaligned = 1'b0;
`endif

  // Only well-formed loads/stores ever reach the bus.
  assign mem_op = (is_load || is_store) && !misaligned;

  // The bus always sees a word address; sub-word position travels in the enables.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^mem_addr_i[1:0];

  assign bus_addr_o  = {mem_addr_i[31:2], 2'b00};
  assign bus_we_o    = is_store;
  assign bus_be_o    = is_store ? store_be(funct3, wr_addr_index_i) : 4'b1111;
  assign bus_wdata_o = is_store ? store_data(funct3, wr_mem_data_i) : 32'h0;

  // The request is combinational, so it is masked while reset is asserted.
  assign bus_req_o = bus_req && rst_n;

  // Upstream holds the instruction until completion, so the bus fields above
  // stay stable from the first request cycle through the grant.
  assign stall_o = (mem_op || (state_q != MEM_IDLE)) && !complete;

  // State register for the access sequencer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bus request and completion; rvalid only counts for a load
  // that is waiting for it or being granted in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    bus_req  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (mem_op) begin
          bus_req = 1'b1;
          if (bus_gnt_i) begin
            if (is_store || bus_rvalid_i) begin
              complete = 1'b1;
            end else begin
              state_d = MEM_WAIT_R;
            end
          end else begin
            state_d = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt_i) begin
          if (is_store || bus_rvalid_i) begin
            complete = 1'b1;
            state_d  = MEM_IDLE;
          end else begin
            state_d = MEM_WAIT_R;
          end
        end
      end
      MEM_WAIT_R: begin
        if (bus_rvalid_i) begin
          complete = 1'b1;
          state_d  = MEM_IDLE;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata  (bus_rdata_i),
    .funct3 (funct3),
    .index  (rd_addr_index_i),
    .data   (load_data)
  );

  // Write-back register: a bubble while stalled or on a rejected access,
  // otherwise the instruction retires with its ALU or load result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg_wdata_o   <= 32'h0;
      wb_wr_reg_en_o   <= 1'b0;
      wb_wr_reg_addr_o <= 5'd0;
      wb_pc_o          <= 32'h0;
      wb_inst_o        <= NOP_INST;
    end else if (stall_o || misaligned) begin
      wb_reg_wdata_o   <= 32'h0;
      wb_wr_reg_en_o   <= 1'b0;
      wb_wr_reg_addr_o <= 5'd0;
      wb_pc_o          <= 32'h0;
      wb_inst_o        <= NOP_INST;
    end else begin
      wb_reg_wdata_o   <= is_load ? load_data : reg_wdata_i;
      wb_wr_reg_en_o   <= is_store ? 1'b0 : wr_reg_en_i;
      wb_wr_reg_addr_o <= wr_reg_addr_i;
      wb_pc_o          <= pc_i;
      wb_inst_o        <= inst_i;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle flag for each rejected misaligned access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= misaligned;
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed scenarios plus randomized loads/stores/ALU ops,
// checked against a transaction-level reference model of the memory stage.
module tb_mem_access;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0]  OPC_ALU   = 7'b0010011;
  localparam logic [6:0]  OPC_LD    = 7'b0000011;
  localparam logic [6:0]  OPC_ST    = 7'b0100011;

  typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE} kind_e;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] reg_wdata_i;
  logic        wr_reg_en_i;
  logic [4:0]  wr_reg_addr_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        wr_mem_en_i;
  logic [31:0] mem_addr_i;
  logic [1:0]  wr_addr_index_i;
  logic [1:0]  rd_addr_index_i;
  logic [31:0] wr_mem_data_i;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        stall_o;
  logic [31:0] wb_reg_wdata_o;
  logic        wb_wr_reg_en_o;
  logic [4:0]  wb_wr_reg_addr_o;
  logic [31:0] wb_pc_o;
  logic [31:0] wb_inst_o;
  logic        misalign_o;

  int          vectors = 0;
  int          miscompares = 0;
  int          txn_id = 0;
  logic [31:0] next_pc = 32'h0000_0400;

  mem_access #(.NOP_INST(NOP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reg_wdata_i      (reg_wdata_i),
    .wr_reg_en_i      (wr_reg_en_i),
    .wr_reg_addr_i    (wr_reg_addr_i),
    .pc_i             (pc_i),
    .inst_i           (inst_i),
    .wr_mem_en_i      (wr_mem_en_i),
    .mem_addr_i       (mem_addr_i),
    .wr_addr_index_i  (wr_addr_index_i),
    .rd_addr_index_i  (rd_addr_index_i),
    .wr_mem_data_i    (wr_mem_data_i),
    .bus_req_o        (bus_req_o),
    .bus_we_o         (bus_we_o),
    .bus_addr_o       (bus_addr_o),
    .bus_wdata_o      (bus_wdata_o),
    .bus_be_o         (bus_be_o),
    .bus_gnt_i        (bus_gnt_i),
    .bus_rvalid_i     (bus_rvalid_i),
    .bus_rdata_i      (bus_rdata_i),
    .stall_o          (stall_o),
    .wb_reg_wdata_o   (wb_reg_wdata_o),
    .wb_wr_reg_en_o   (wb_wr_reg_en_o),
    .wb_wr_reg_addr_o (wb_wr_reg_addr_o),
    .wb_pc_o          (wb_pc_o),
    .wb_inst_o        (wb_inst_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: value a load writes back, from the architectural rules.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] word,
                                           input int off);
    int unsigned v, b, h;
    logic [31:0] r;
    v = word / (32'd1 << (8 * off));
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'b000:  r = (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  r = (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  r = b;
      3'b101:  r = h;
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] f3, input int off);
    case (f3)
      3'b000:  return (32'd1 << off) % 16;
      3'b001:  return (32'd3 << off) % 16;
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return (d % 256) * 32'h0101_0101;
      3'b001:  return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic drive_idle();
    inst_i          = NOP;
    pc_i            = 32'h0;
    reg_wdata_i     = 32'h0;
    wr_reg_en_i     = 1'b0;
    wr_reg_addr_i   = 5'd0;
    wr_mem_en_i     = 1'b0;
    mem_addr_i      = 32'h0;
    wr_addr_index_i = 2'd0;
    rd_addr_index_i = 2'd0;
    wr_mem_data_i   = 32'h0;
    bus_gnt_i       = 1'b0;
    bus_rvalid_i    = 1'b0;
    bus_rdata_i     = 32'h0;
  endtask

  // One instruction through the stage. Entered 1 time unit after a rising edge.
  // gd = cycles of request before grant; rd = cycles from grant to rvalid.
  task automatic run_txn(input kind_e kind, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata,
                         input int gd, input int rd, input logic [4:0] rd_reg,
                         input logic reg_en);
    logic [6:0]  opc;
    logic [31:0] inst, pc, exp_wd;
    int          done, off;
    txn_id++;
    off  = int'(addr[1:0]);
    opc  = (kind == K_LOAD) ? OPC_LD : (kind == K_STORE) ? OPC_ST : OPC_ALU;
    inst = {17'h0, f3, rd_reg, opc};
    pc   = next_pc;
    next_pc = next_pc + 4;
    done = (kind == K_ALU) ? 0 : (kind == K_STORE) ? gd : gd + rd;

    inst_i          = inst;
    pc_i            = pc;
    reg_wdata_i     = (kind == K_ALU) ? data : addr;
    wr_reg_en_i     = reg_en;
    wr_reg_addr_i   = rd_reg;
    wr_mem_en_i     = (kind == K_STORE);
    mem_addr_i      = addr;
    wr_addr_index_i = addr[1:0];
    rd_addr_index_i = addr[1:0];
    wr_mem_data_i   = data;

    for (int c = 0; c <= done; c++) begin
      bus_gnt_i    = (kind != K_ALU) && (c == gd);
      // ALU ops get stray rvalids, which must be ignored.
      bus_rvalid_i = (kind == K_LOAD) ? (c == gd + rd) : (kind == K_ALU) ? 1'($urandom % 2) : 1'b0;
      bus_rdata_i  = ((kind == K_LOAD) && (c == gd + rd)) ? rdata : $urandom;
      #3;
      check($sformatf("t%0d.c%0d.stall", txn_id, c), 32'(stall_o), 32'(c < done));
      check($sformatf("t%0d.c%0d.bus_req", txn_id, c), 32'(bus_req_o),
            32'((kind != K_ALU) && (c <= gd)));
      if (c == 0 && kind != K_ALU) begin
        check($sformatf("t%0d.bus_addr", txn_id), bus_addr_o, addr & 32'hFFFF_FFFC);
        check($sformatf("t%0d.bus_we", txn_id), 32'(bus_we_o), 32'(kind == K_STORE));
        if (kind == K_STORE) begin
          check($sformatf("t%0d.bus_be", txn_id), 32'(bus_be_o), ref_be(f3, off));
          check($sformatf("t%0d.bus_wdata", txn_id), bus_wdata_o, ref_wdata(f3, data));
        end
      end
      @(posedge clk);
      #1;
      if (c < done) begin
        check($sformatf("t%0d.c%0d.bubble_en", txn_id, c), 32'(wb_wr_reg_en_o), 32'd0);
        check($sformatf("t%0d.c%0d.bubble_inst", txn_id, c), wb_inst_o, NOP);
      end else begin
        exp_wd = (kind == K_LOAD) ? ref_load(f3, rdata, off) : data;
        if (kind != K_STORE)
          check($sformatf("t%0d.wb_wdata", txn_id), wb_reg_wdata_o, exp_wd);
        check($sformatf("t%0d.wb_en", txn_id), 32'(wb_wr_reg_en_o),
              32'(reg_en && (kind != K_STORE)));
        check($sformatf("t%0d.wb_addr", txn_id), 32'(wb_wr_reg_addr_o), 32'(rd_reg));
        check($sformatf("t%0d.wb_pc", txn_id), wb_pc_o, pc);
        check($sformatf("t%0d.wb_inst", txn_id), wb_inst_o, inst);
        check($sformatf("t%0d.misalign", txn_id), 32'(misalign_o), 32'd0);
      end
    end
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    kind_e      kind;
    logic [2:0] f3;
    int         off;
    logic [31:0] addr;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset values.
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.bus_req", 32'(bus_req_o), 32'd0);
    check("rst.wb_wdata", wb_reg_wdata_o, 32'h0);
    check("rst.wb_en", 32'(wb_wr_reg_en_o), 32'd0);
    check("rst.wb_addr", 32'(wb_wr_reg_addr_o), 32'd0);
    check("rst.wb_pc", wb_pc_o, 32'h0);
    check("rst.wb_inst", wb_inst_o, NOP);
    check("rst.misalign", 32'(misalign_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi result 5: one-cycle latency, no stall.
    run_txn(K_ALU, 3'b000, 32'h0, 32'h5, 32'h0, 0, 0, 5'd1, 1'b1);
    // SB 0xAB at 0x1002, grant after two waiting cycles.
    run_txn(K_STORE, 3'b000, 32'h1002, 32'h1234_56AB, 32'h0, 2, 0, 5'd0, 1'b1);
    // LB at 0x1003, rvalid three cycles after grant.
    run_txn(K_LOAD, 3'b000, 32'h1003, 32'h0, 32'h8000_0000, 1, 3, 5'd7, 1'b1);
    // LHU at 0x1002, zero-wait: grant and rvalid together.
    run_txn(K_LOAD, 3'b101, 32'h1002, 32'h0, 32'hBEEF_0000, 0, 0, 5'd9, 1'b1);
    // SW with grant immediately.
    run_txn(K_STORE, 3'b010, 32'h2000, 32'hCAFE_F00D, 32'h0, 0, 0, 5'd3, 1'b1);

    // Reset while waiting for read data; a late rvalid must be ignored.
    drive_idle();
    inst_i        = {17'h0, 3'b010, 5'd4, OPC_LD};
    pc_i          = 32'h0000_0900;
    wr_reg_en_i   = 1'b1;
    wr_reg_addr_i = 5'd4;
    mem_addr_i    = 32'h3000;
    bus_gnt_i     = 1'b1;
    @(posedge clk);
    #1;
    bus_gnt_i = 1'b0;
    #3;
    check("rstw.stall_wait", 32'(stall_o), 32'd1);
    check("rstw.req_wait", 32'(bus_req_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw.bus_req", 32'(bus_req_o), 32'd0);
    check("rstw.wb_en", 32'(wb_wr_reg_en_o), 32'd0);
    check("rstw.wb_inst", wb_inst_o, NOP);
    drive_idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    #3;
    check("rstw.late_stall", 32'(stall_o), 32'd0);
    check("rstw.late_req", 32'(bus_req_o), 32'd0);
    @(posedge clk);
    #1;
    bus_rvalid_i = 1'b0;
    check("rstw.late_wdata", wb_reg_wdata_o, 32'h0);
    check("rstw.late_en", 32'(wb_wr_reg_en_o), 32'd0);
    check("rstw.late_inst", wb_inst_o, NOP);

`ifdef MEM_ALIGN_CHECK_EN
    // LW at 0x1001 is rejected without touching the bus.
    inst_i          = {17'h0, 3'b010, 5'd6, OPC_LD};
    pc_i            = 32'h0000_0A00;
    wr_reg_en_i     = 1'b1;
    wr_reg_addr_i   = 5'd6;
    mem_addr_i      = 32'h1001;
    rd_addr_index_i = 2'd1;
    #3;
    check("mis.bus_req", 32'(bus_req_o), 32'd0);
    check("mis.stall", 32'(stall_o), 32'd0);
    @(posedge clk);
    #1;
    check("mis.pulse", 32'(misalign_o), 32'd1);
    check("mis.wb_en", 32'(wb_wr_reg_en_o), 32'd0);
    drive_idle();
    @(posedge clk);
    #1;
    check("mis.pulse_end", 32'(misalign_o), 32'd0);
`endif

    // Randomized mix of ALU ops, loads and stores with random bus latency.
    for (int n = 0; n < 40; n++) begin
      kind = kind_e'($urandom_range(0, 2));
      if (kind == K_LOAD) f3 = ld_f3[$urandom_range(0, 4)];
      else if (kind == K_STORE) f3 = 3'($urandom_range(0, 2));
      else f3 = 3'($urandom_range(0, 7));
      if (kind == K_ALU || f3[1:0] == 2'b00) off = $urandom_range(0, 3);
      else if (f3[1:0] == 2'b01) off = $urandom_range(0, 2);
      else off = 0;
      addr = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      run_txn(kind, f3, addr, $urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), 5'($urandom_range(0, 31)), 1'($urandom % 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter: NOP_INST, 32'h00000013, instruction word driven on wb_inst_o during reset and bubbles.
REQ-002 SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reg_wdata_i  in  32  ALU result.
- wr_reg_en_i  in  1  register write enable from ALU.
- wr_reg_addr_i  in  5  destination register.
- pc_i  in  32  PC of the instruction.
- inst_i  in  32  instruction word.
- wr_mem_en_i  in  1  store instruction present.
- mem_addr_i  in  32  effective address.
- wr_addr_index_i  in  2  store byte offset.
- rd_addr_index_i  in  2  load byte offset.
- wr_mem_data_i  in  32  store data (rs2).
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word-aligned address.
- bus_wdata_o  out  32  lane-shifted store data.
- bus_be_o  out  4  byte enables.
- bus_gnt_i  in  1  request accepted.
- bus_rvalid_i  in  1  read data valid.
- bus_rdata_i  in  32  read data.
- stall_o  out  1  hold upstream stages.
- wb_reg_wdata_o  out  32  registered write-back data.
- wb_wr_reg_en_o  out  1  registered write enable.
- wb_wr_reg_addr_o  out  5  registered destination.
- wb_pc_o  out  32  registered PC.
- wb_inst_o  out  32  registered instruction.
- misalign_o  out  1  misaligned-access pulse (macro only).

Function
REQ-003 SHALL decode a load as inst_i[6:0]=7'b0000011 and a store as wr_mem_en_i=1; every other instruction passes through with 1-cycle latency and stall_o=0.
REQ-004 SHALL implement FSM IDLE -> REQ -> WAIT_R -> IDLE. From IDLE, a load or store moves to REQ. REQ moves to IDLE on gnt for a store, or to WAIT_R on gnt for a load. WAIT_R moves to IDLE on rvalid.
REQ-005 SHALL assert bus_req_o combinationally in IDLE when a memory instruction is present, and in REQ; bus_addr_o/we/be/wdata SHALL hold stable until gnt.
REQ-006 SHALL set bus_addr_o = {mem_addr_i[31:2],2'b00}.
REQ-007 SHALL generate store enables from funct3 and wr_addr_index_i: SB -> 4'b0001<<idx; SH -> 4'b0011<<idx; SW -> 4'b1111. bus_wdata_o SHALL be the data replicated to the selected lanes.
REQ-008 SHALL extract loads by rd_addr_index_i: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; the result is written to wb_reg_wdata_o on the edge where rvalid=1.
REQ-009 SHALL drive stall_o=1 while a memory instruction is in flight and not completing this cycle: store through the cycle before gnt, load through the cycle before rvalid.
REQ-010 SHALL NOT start a new request until the current one completes (one outstanding access).
REQ-011 SHALL drive wb outputs as a bubble while stalled: wr_reg_en=0, inst=NOP_INST.
REQ-012 SHALL treat gnt and rvalid in the same cycle (zero-wait load) as completion directly from REQ or IDLE.
REQ-013 SHALL ignore rvalid outside WAIT_R.
REQ-014 SHALL write a store's wb_wr_reg_en_o as 0 regardless of the input.

Reset
REQ-015 SHALL, on rst_n=0, immediately set FSM=IDLE, bus_req_o=0, wb_reg_wdata_o=0, wb_wr_reg_en_o=0, wb_wr_reg_addr_o=0, wb_pc_o=0, wb_inst_o=NOP_INST, misalign_o=0, and drop any in-flight access; a late rvalid SHALL be ignored.

Configuration
REQ-016 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a halfword at offset 3 or a word at a nonzero offset as misaligned: no bus request, misalign_o pulses 1 cycle, and write-back is suppressed. Without the macro, misalign_o SHALL be tied 0 and the address SHALL be truncated as in REQ-006.

Structure
REQ-017 SHALL place opcode/funct3 constants and the FSM state enum in shared package cpu_defs_pkg.
REQ-018 SHALL have one sub-module, load_align, which does lane select and sign extension combinationally.

Verification
REQ-019 The bench SHALL cover these scenarios:
- addi result 0x5 -> wb_reg_wdata_o=0x5 one cycle later, stall_o never 1.
- SB 0xAB at addr 0x1002, gnt after 2 cycles -> be=4'b0100, wdata=0xABABABAB, stall_o 2 cycles.
- LB at 0x1003, rdata=0x80000000, rvalid 3 cycles after gnt -> wb_reg_wdata_o=0xFFFFFF80.
- LHU at 0x1002, rdata=0xBEEF0000, gnt and rvalid same cycle -> 0x0000BEEF, no stall.
- rst_n low in WAIT_R, rvalid arrives later -> FSM IDLE, outputs reset, no write-back.
- With the macro, LW at 0x1001 -> misalign_o pulse, bus_req_o=0.
